// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the instruction-fetch engine.
// Imported by fetch_assembler and fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  function automatic int lat_w(input int lat);
    return $clog2(lat + 1);
  endfunction

  function automatic int idx_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/fetch_assembler.sv
// Collects flash bytes LSB-first into the instruction register.
// Lanes not rewritten keep the previous instruction's bytes.
module fetch_assembler
  import fetch_pkg::*;
#(
  parameter int INSTR_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [7:0]               byte_i,
  output logic [8*INSTR_BYTES-1:0] ir_o,
  output logic                     last_o
);

  localparam int IW = idx_w(INSTR_BYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(INSTR_BYTES - 1);

  logic [IW-1:0]              idx_q;
  logic [8*INSTR_BYTES-1:0]   ir_q;

  assign last_o = (idx_q == IDX_LAST);
  assign ir_o   = ir_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      ir_q  <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (load) begin
      for (int k = 0; k < INSTR_BYTES; k++) begin
        if (idx_q == IW'(k)) ir_q[8*k +: 8] <= byte_i;
      end
      idx_q <= last_o ? '0 : idx_q + IW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: owns the PC, reads flash one byte at a time
// and offers each assembled instruction over a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 24,
  parameter int                INSTR_BYTES = 4,
  parameter int                READ_LAT    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_cs,
  output logic                     mem_re,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic [8*INSTR_BYTES-1:0] ir,
  output logic [ADDR_W-1:0]        ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy
);

  localparam int CW = lat_w(READ_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] irpc_q, irpc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q, valid_q, busy_q;
  logic              clear, load, last;

  fetch_assembler #(
    .INSTR_BYTES(INSTR_BYTES)
  ) u_asm (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (load),
    .byte_i (mem_rdata),
    .ir_o   (ir),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    irpc_d  = irpc_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    load    = 1'b0;
    if (redirect) begin
      pc_d    = redirect_pc;
      irpc_d  = redirect_pc;
      clear   = 1'b1;
      state_d = en ? S_REQ : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d = S_REQ;
            irpc_d  = pc_q;
          end
        end
        S_REQ: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            load    = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = last ? S_HOLD : S_REQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            state_d = en ? S_REQ : S_IDLE;
            if (en) irpc_d = pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Flash strobes are registered from the next state so inputs never reach them combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      irpc_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      irpc_q  <= irpc_d;
      cnt_q   <= cnt_d;
      cs_q    <= (state_d == S_REQ) || (state_d == S_WAIT);
      valid_q <= (state_d == S_HOLD);
      busy_q  <= (state_d != S_IDLE);
      if (state_d == S_REQ) addr_q <= pc_d;
    end
  end

  assign mem_cs   = cs_q;
  assign mem_re   = cs_q;
  assign mem_addr = addr_q;
  assign ir_pc    = irpc_q;
  assign ir_valid = valid_q;
  assign pc       = pc_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus a randomized
// stream compared against a flash-content model of the instruction sequence.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] fmem [bit [23:0]];

  function automatic logic [7:0] frd(input logic [23:0] a);
    if (fmem.exists(a)) return fmem[a];
    return 8'(a * 13 + 7) ^ 8'(a >> 8);
  endfunction

  function automatic logic [31:0] word(input logic [23:0] a, input int nb);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < nb; i++) w[8*i +: 8] = frd(a + 24'(i));
    return w;
  endfunction

  task automatic put(input logic [23:0] a, input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) fmem[a + 24'(i)] = w[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // main instance: defaults
  logic        m_en = 0, m_redir = 0, m_ready = 0;
  logic [23:0] m_rpc = '0, m_addr, m_irpc, m_pc;
  logic        m_cs, m_re, m_valid, m_busy;
  logic [7:0]  m_rd = '0;
  logic [31:0] m_ir;

  fetch_unit #(.ADDR_W(24), .INSTR_BYTES(4), .READ_LAT(3),
               .RESET_PC(24'h000000)) u_main (
    .clk(clk), .rst(rst), .en(m_en), .redirect(m_redir),
    .redirect_pc(m_rpc), .mem_cs(m_cs), .mem_re(m_re),
    .mem_addr(m_addr), .mem_rdata(m_rd), .ir(m_ir), .ir_pc(m_irpc),
    .ir_valid(m_valid), .ir_ready(m_ready), .pc(m_pc), .busy(m_busy)
  );

  // wrap instance: reset vector near the top of the address space
  logic        w_en = 0, w_ready = 0;
  logic [23:0] w_addr, w_irpc, w_pc;
  logic        w_cs, w_re, w_valid, w_busy;
  logic [7:0]  w_rd = '0;
  logic [31:0] w_ir;

  fetch_unit #(.ADDR_W(24), .INSTR_BYTES(4), .READ_LAT(3),
               .RESET_PC(24'hFFFFFE)) u_wrap (
    .clk(clk), .rst(rst), .en(w_en), .redirect(1'b0),
    .redirect_pc(24'h0), .mem_cs(w_cs), .mem_re(w_re),
    .mem_addr(w_addr), .mem_rdata(w_rd), .ir(w_ir), .ir_pc(w_irpc),
    .ir_valid(w_valid), .ir_ready(w_ready), .pc(w_pc), .busy(w_busy)
  );

  // variant instance: 2-byte instructions, 1-cycle flash
  logic        v_en = 0, v_ready = 0;
  logic [23:0] v_addr, v_irpc, v_pc;
  logic        v_cs, v_re, v_valid, v_busy;
  logic [7:0]  v_rd = '0;
  logic [15:0] v_ir;

  fetch_unit #(.ADDR_W(24), .INSTR_BYTES(2), .READ_LAT(1),
               .RESET_PC(24'h000000)) u_var (
    .clk(clk), .rst(rst), .en(v_en), .redirect(1'b0),
    .redirect_pc(24'h0), .mem_cs(v_cs), .mem_re(v_re),
    .mem_addr(v_addr), .mem_rdata(v_rd), .ir(v_ir), .ir_pc(v_irpc),
    .ir_valid(v_valid), .ir_ready(v_ready), .pc(v_pc), .busy(v_busy)
  );

  // flash model: real data while selected, noise otherwise
  always @(negedge clk) begin
    m_rd = (m_cs && m_re) ? frd(m_addr) : 8'($urandom);
    w_rd = (w_cs && w_re) ? frd(w_addr) : 8'($urandom);
    v_rd = (v_cs && v_re) ? frd(v_addr) : 8'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vld(input int d);
    case (d)
      0:       return m_valid;
      1:       return w_valid;
      default: return v_valid;
    endcase
  endfunction

  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (!vld(d) && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [31:0] exp_w [3];
  logic [31:0] held;
  logic [23:0] exp_pc;
  logic        hv, acc;
  int          n, nacc;

  initial begin
    exp_w[0] = 32'h02000283;
    exp_w[1] = 32'h02100303;
    exp_w[2] = 32'h006283B3;

    tick();
    tick();
    chk("rst_cs", m_cs, 0);
    chk("rst_re", m_re, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_ir", m_ir, 0);
    chk("rst_irpc", m_irpc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_pc", m_pc, 0);
    chk("rst_wpc", w_pc, 24'hFFFFFE);
    rst = 1'b1;

    // single fetch
    for (int i = 0; i < 3; i++) put(24'(4 * i), exp_w[i], 4);
    m_en = 1;
    tick();
    chk("req_cs", m_cs, 1);
    chk("req_addr", m_addr, 0);
    chk("req_busy", m_busy, 1);
    wait_valid(0, n);
    chk("fill_lat", 32'(n), 16);
    chk("single_ir", m_ir, 32'h02000283);
    chk("single_irpc", m_irpc, 0);
    chk("single_pc", m_pc, 24'h000004);
    chk("hold_cs", m_cs, 0);
    m_en = 0;
    m_ready = 1;
    tick();
    m_ready = 0;
    chk("idle_valid", m_valid, 0);
    chk("idle_busy", m_busy, 0);

    // stream with back-pressure
    do_reset();
    m_en = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, n);
      chk("s_lat", 32'(n), 16);
      chk("s_ir", m_ir, exp_w[i]);
      chk("s_irpc", m_irpc, 24'(4 * i));
      if (i == 1) begin
        held = m_ir;
        for (int c = 0; c < 5; c++) begin
          tick();
          chk("bp_valid", m_valid, 1);
          chk("bp_ir", m_ir, held);
          chk("bp_cs", m_cs, 0);
        end
      end
      if (i == 2) m_en = 0;
      m_ready = 1;
      tick();
      m_ready = 0;
    end
    chk("s_end_valid", m_valid, 0);

    // redirect during the byte-2 wait
    do_reset();
    put(24'h00000C, 32'h02700123, 4);
    m_en = 1;
    tick();
    repeat (9) tick();
    chk("rd_addr2", m_addr, 2);
    m_redir = 1;
    m_rpc = 24'h00000C;
    tick();
    m_redir = 0;
    chk("rd_addr", m_addr, 24'h00000C);
    chk("rd_cs", m_cs, 1);
    chk("rd_pc", m_pc, 24'h00000C);
    chk("rd_valid", m_valid, 0);
    wait_valid(0, n);
    chk("rd_lat", 32'(n), 16);
    chk("rd_irpc", m_irpc, 24'h00000C);
    chk("rd_ir", m_ir, 32'h02700123);
    m_en = 0;
    m_ready = 1;
    tick();
    m_ready = 0;

    // reset during the byte-1 wait
    do_reset();
    m_en = 1;
    tick();
    repeat (5) tick();
    chk("rm_addr1", m_addr, 1);
    rst = 0;
    tick();
    chk("rm_cs", m_cs, 0);
    chk("rm_valid", m_valid, 0);
    chk("rm_pc", m_pc, 0);
    chk("rm_busy", m_busy, 0);
    chk("rm_addr", m_addr, 0);
    tick();
    chk("rm_cs_held", m_cs, 0);
    rst = 1;
    tick();
    chk("rm_restart_cs", m_cs, 1);
    chk("rm_restart_addr", m_addr, 0);
    wait_valid(0, n);
    chk("rm_lat", 32'(n), 16);
    chk("rm_ir", m_ir, 32'h02000283);
    chk("rm_irpc", m_irpc, 0);
    m_en = 0;
    m_ready = 1;
    tick();
    m_ready = 0;

    // random stream: ready and redirects; model tracks expected start address
    do_reset();
    exp_pc = 24'h000000;
    nacc = 0;
    m_en = 1;
    for (int c = 0; c < 1500; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      m_redir = ($urandom_range(0, 39) == 0);
      m_rpc = ($urandom_range(0, 3) == 0) ?
              24'hFFFFFF - 24'($urandom_range(0, 5)) :
              24'($urandom_range(0, 4095));
      if (m_valid) chk("r_hold_cs", m_cs, 0);
      acc = m_valid && m_ready && !m_redir;
      if (acc) begin
        chk("r_irpc", m_irpc, exp_pc);
        chk("r_ir", m_ir, word(exp_pc, 4));
        exp_pc = exp_pc + 24'd4;
        nacc++;
      end
      if (m_redir) exp_pc = m_rpc;
      hv = m_valid && !m_ready && !m_redir;
      held = m_ir;
      tick();
      if (hv) begin
        chk("r_stable_v", m_valid, 1);
        chk("r_stable_ir", m_ir, held);
      end
    end
    chk("r_accepts", 32'(nacc > 10), 1);
    m_redir = 0;
    m_en = 0;
    m_ready = 1;
    repeat (40) tick();
    chk("r_drain_valid", m_valid, 0);
    chk("r_drain_busy", m_busy, 0);
    m_ready = 0;

    // wrap-around across the top of the address space
    do_reset();
    put(24'hFFFFFE, 32'hDDCCBBAA, 4);
    chk("w_rst_pc", w_pc, 24'hFFFFFE);
    w_en = 1;
    tick();
    chk("w_req_addr", w_addr, 24'hFFFFFE);
    wait_valid(1, n);
    chk("w_lat", 32'(n), 16);
    chk("w_ir", w_ir, 32'hDDCCBBAA);
    chk("w_irpc", w_irpc, 24'hFFFFFE);
    chk("w_pc", w_pc, 24'h000002);
    w_en = 0;
    w_ready = 1;
    tick();
    w_ready = 0;

    // 2-byte / 1-cycle variant, back-to-back
    do_reset();
    put(24'h000000, 32'h00001234, 2);
    put(24'h000002, 32'h0000ABCD, 2);
    v_en = 1;
    tick();
    wait_valid(2, n);
    chk("v_lat", 32'(n), 4);
    chk("v_ir", v_ir, 32'h1234);
    chk("v_irpc", v_irpc, 0);
    chk("v_pc", v_pc, 2);
    v_ready = 1;
    tick();
    v_ready = 0;
    wait_valid(2, n);
    chk("v_lat2", 32'(n), 4);
    chk("v_ir2", v_ir, 32'hABCD);
    chk("v_irpc2", v_irpc, 2);
    v_en = 0;
    v_ready = 1;
    tick();
    v_ready = 0;
    chk("v_idle", v_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
